// File: rtl/stream_mux.sv
// stream_mux: N-to-1 stream multiplexer, select-driven or round-robin; optional xfer_count via STREAM_MUX_COUNT_EN.
// Latency: 1 cycle from input transfer to out_valid, one output register stage.
// Backpressure: in_ready follows load_ok (empty or leaving this cycle); full throughput with no bubble.
module stream_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef STREAM_MUX_COUNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  int unsigned      rr_cand;
  logic             load_ok;
  logic             load;
  logic [WIDTH-1:0] grant_dat;

  assign load_ok = !out_valid || out_ready;

  // Round-robin search starts just after the last granted channel and wraps.
  always_comb begin
    rr_vld  = 1'b0;
    rr_idx  = '0;
    rr_cand = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_cand = int'(rr_ptr) + k;
      if (rr_cand >= CHANNELS) rr_cand = rr_cand - CHANNELS;
      if (!rr_vld && in_valid[rr_cand]) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'(rr_cand);
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else if (int'(sel) < CHANNELS) begin
      grant_vld = 1'b1;
      grant_idx = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld) in_ready[grant_idx] = load_ok;
  end

  assign load      = |(in_valid & in_ready);
  assign grant_dat = in_data[grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant_dat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pointer only moves on accepted round-robin grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SEL_W'(CHANNELS - 1);
    end else if (load && mode) begin
      rr_ptr <= grant_idx;
    end
  end

`ifdef STREAM_MUX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready && xfer_count != 16'hFFFF) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Randomized and directed bench for stream_mux (WIDTH=4, CHANNELS=4) against a transaction-level model.
module tb_stream_mux;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel = '0;
  logic           mode = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef STREAM_MUX_COUNT_EN
  logic [15:0]    xfer_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: held beat, last round-robin winner, saturating transfer count.
  bit       m_vld;
  int       m_data;
  int       m_last;
  int       m_cnt;

  stream_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_MUX_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = 0;
    m_last = N - 1;
    m_cnt  = 0;
  endtask

  task automatic drive(input bit md, input int s, input int vld, input logic [N*W-1:0] d, input bit ordy);
    mode      = md;
    sel       = 2'(s);
    in_valid  = 4'(vld);
    in_data   = d;
    out_ready = ordy;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic step();
    bit   gv;
    int   g;
    bit   lok;
    logic [N-1:0] exp_rdy;
    bit   ordy;
    logic [N-1:0] vld;
    logic [N*W-1:0] dat;
    gv = 1'b0;
    g  = 0;
    if (!mode) begin
      gv = 1'b1;
      g  = int'(sel);
    end else begin
      for (int k = 1; k <= N && !gv; k++) begin
        if (in_valid[(m_last + k) % N]) begin
          gv = 1'b1;
          g  = (m_last + k) % N;
        end
      end
    end
    lok = !m_vld || out_ready;
    exp_rdy = '0;
    if (gv && lok) exp_rdy[g] = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    ordy = out_ready;
    vld  = in_valid;
    dat  = in_data;
    @(posedge clk);
    if (m_vld && ordy && m_cnt < 16'hFFFF) m_cnt++;
    if (gv && lok && vld[g]) begin
      m_vld  = 1'b1;
      m_data = int'(dat[g*W +: W]);
      if (mode) m_last = g;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
`ifdef STREAM_MUX_COUNT_EN
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pending beat 0xA, then reset with it stalled.
    drive(1'b0, 0, 4'b0001, 16'h000A, 1'b0);
    step();
    chk("pend_data", 32'(out_data), 32'hA);
    do_reset();

    // Select mode, channel 2.
    drive(1'b0, 2, 4'b0100, 16'h0900, 1'b1);
    step();
    chk("sel2_data", 32'(out_data), 32'h9);
    chk("sel2_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 2, 4'b0100, 16'h0500, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'h9);
    end
    out_ready = 1'b1;
    step();
    chk("swap_data", 32'(out_data), 32'h5);
    chk("swap_valid", 32'(out_valid), 32'd1);

    // Round-robin with all requesting: 0,1,2,3,0.
    do_reset();
    drive(1'b1, 0, 4'b1111, 16'h4321, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_all", 32'(out_data), 32'((i % N) + 1));
    end

    // Wrap from pointer 3: grant 0 then 3.
    do_reset();
    drive(1'b1, 0, 4'b1001, 16'h8001, 1'b1);
    step();
    chk("wrap_first", 32'(out_data), 32'h1);
    step();
    chk("wrap_second", 32'(out_data), 32'h8);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            16'($urandom), $urandom_range(0, 3) != 0);
      step();
    end

`ifdef STREAM_MUX_COUNT_EN
    do_reset();
    drive(1'b0, 1, 4'b0010, 16'h0070, 1'b1);
    for (int i = 0; i < 65541; i++) @(negedge clk);
    chk("count_sat", 32'(xfer_count), 32'hFFFF);
    chk("count_sat_data", 32'(out_data), 32'h7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 2, number of input streams (>=2); SEL_W = clog2(CHANNELS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  CHANNELS  per-channel valid.
REQ-007 in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-008 sel  input  SEL_W  channel select, used in mode 0.
REQ-009 mode  input  1  0 = select-driven, 1 = round-robin arbitration.
REQ-010 out_data  output  WIDTH  registered data.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_ready  input  1  downstream accepts beat.

Function
REQ-013 Transfer on any port occurs when valid and ready are both high at a rising edge.
REQ-014 Single output register stage; latency 1 cycle from input transfer to out_valid.
REQ-015 Stage can load when empty or when its beat leaves this cycle: load_ok = !out_valid || out_ready.
REQ-016 Mode 0: in_ready[sel] = load_ok; all other in_ready bits 0; sel >= CHANNELS grants nothing.
REQ-017 Mode 1: grant the first channel with in_valid high, searching from rr_ptr+1 upward with wrap to 0; in_ready[grant] = load_ok.
REQ-018 rr_ptr updates to the granted index only on an accepted input transfer; no request -> rr_ptr holds.
REQ-019 in_ready is combinational from in_valid, sel, mode, rr_ptr, out_valid, out_ready; no path from in_data.
REQ-020 Loaded beat: out_data <= granted channel data, out_valid <= 1.
REQ-021 Beat leaves with no new load: out_valid <= 0, out_data holds its last value.
REQ-022 Simultaneous leave and load: new beat replaces old in the same edge, out_valid stays 1, no bubble.
REQ-023 out_valid=1 and out_ready=0: out_data and out_valid stable; all in_ready 0.
REQ-024 mode or sel change takes effect in the same cycle for grant only; a beat already registered is unaffected.
REQ-025 Sustained throughput 1 beat/cycle while out_ready=1 and a granted channel is valid.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, rr_ptr=CHANNELS-1 (channel 0 wins first round-robin search), xfer_count=0 if present.
REQ-027 Reset mid-transfer discards the registered beat; no output transfer is counted or presented.
REQ-028 First load possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro STREAM_MUX_COUNT_EN defined: adds output xfer_count [15:0], incremented on each output transfer, saturates at 16'hFFFF.
REQ-030 STREAM_MUX_COUNT_EN undefined: no xfer_count port, no counter logic; all other behaviour identical.

Verification (WIDTH=4, CHANNELS=4)
REQ-031 Reset with out_valid=1, out_data=4'hA pending -> out_valid=0, out_data=0 immediately, before any clock edge.
REQ-032 mode=0, sel=2, in_valid=4'b0100, ch2 data=4'h9, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'h9.
REQ-033 mode=0, sel=2, in_valid=4'b0100, out_ready=0 for 3 cycles after first load -> in_ready=0, out_data stable 3 cycles; out_ready=1 -> beat leaves, next ch2 beat loads same edge.
REQ-034 mode=1, in_valid=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-035 mode=1, rr_ptr=3, in_valid=4'b1001 -> grant 0; next cycle grant 3 (wrap check).
REQ-036 With STREAM_MUX_COUNT_EN, 65540 output transfers -> xfer_count=16'hFFFF; without the macro, same stimulus produces identical out_data sequence.
